// File: rtl/axis_bpr_cross_interp_if.sv
// AXI4-Stream bundle shared by the input and output sides of the bad-pixel replacer.
// A beat transfers on a rising clock edge where tvalid and tready are both 1; once tvalid
// is raised the source holds tdata/tlast/tuser stable and keeps tvalid high until that edge.
interface axis_bpr_cross_interp_if #(
    parameter int TDATA_WIDTH = 16
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic                   tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_bpr_cross_interp.sv
// Streaming bad-pixel replacer: two internal line buffers, cross-neighbour interpolation,
// frame-start resynchronisation and per-frame bad/unfixable pixel statistics.
module axis_bpr_cross_interp #(
    parameter int IMG_RES_X    = 336,
    parameter int IMG_RES_Y    = 256,
    parameter int TDATA_WIDTH  = 16,
    parameter int PIX_WIDTH    = 14,
    parameter int BAD_FLAG_BIT = 15,
    parameter int CNT_WIDTH    = $clog2(IMG_RES_X*IMG_RES_Y+1)
) (
    input  logic                   axis_aclk,
    input  logic                   axis_aresetn,
    input  logic                   bypass,
    input  logic                   mode,
    axis_bpr_cross_interp_if.slave  s_axis,
    axis_bpr_cross_interp_if.master m_axis,
    output logic [CNT_WIDTH-1:0]   bad_cnt,
    output logic [CNT_WIDTH-1:0]   unfix_cnt,
    output logic                   sync_err,
    output logic [1:0]             dbg_state
);
    localparam int XW = $clog2(IMG_RES_X);
    localparam int YW = $clog2(IMG_RES_Y);
    localparam int PW = PIX_WIDTH;

    typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;
    state_t state_q, state_d;

    logic [XW-1:0]          x_q;
    logic [YW-1:0]          y_q;
    logic                   live_q;
    logic                   bypass_q;
    logic                   mode_q;
    logic                   flush_issued_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic                   m_user_q;
    logic [TDATA_WIDTH-1:0] m_data_q;
    logic [PW-1:0]          last_pix_q;
    logic [PW:0]            l_q;
    logic [CNT_WIDTH-1:0]   frm_bad_q;
    logic [CNT_WIDTH-1:0]   frm_unfix_q;

    // Each word is {flag, pixel}; mid holds output row y, up holds row y-1.
    logic [PW:0] mid_mem [IMG_RES_X];
    logic [PW:0] up_mem  [IMG_RES_X];

    logic          x_last, y_last_in, at_origin, out_slot, s_ready, in_hs, sof;
    logic          restart, fill_adv, run_beat, flush_beat, flush_done, emit;
    logic [XW-1:0] r_addr, wr_addr;
    logic [PW:0]   in_word, c_word, r_word, u_word;
    logic          l_ok, r_ok, u_ok, d_ok;
    logic [PW:0]   sum_h, sum_v;
    logic [PW-1:0] avg_h, avg_v, repl, out_pix;
    logic          no_nb, unfix_hit;
    logic          unused_bits;

    assign unused_bits = ^{s_axis.tlast, s_axis.tdata};

    assign x_last     = (x_q == XW'(IMG_RES_X-1));
    assign y_last_in  = (y_q == YW'(IMG_RES_Y-2));
    assign at_origin  = (state_q == ST_FILL) && (x_q == '0);
    assign out_slot   = !m_valid_q || m_axis.tready;
    assign s_ready    = live_q && ((state_q == ST_FILL) || ((state_q == ST_RUN) && out_slot));
    assign in_hs      = s_axis.tvalid && s_ready;
    assign sof        = s_axis.tuser;
    // Any accepted tuser beat starts a frame, whether expected at (0,0) or a resync.
    assign restart    = in_hs && sof;
    assign fill_adv   = in_hs && !sof && (state_q == ST_FILL) && (x_q != '0);
    assign run_beat   = in_hs && !sof && (state_q == ST_RUN);
    assign flush_beat = (state_q == ST_FLUSH) && !flush_issued_q && out_slot;
    assign flush_done = (state_q == ST_FLUSH) && flush_issued_q && m_valid_q && m_axis.tready;
    assign emit       = run_beat || flush_beat;

    assign in_word = {s_axis.tdata[BAD_FLAG_BIT], s_axis.tdata[PW-1:0]};
    assign r_addr  = x_last ? x_q : x_q + XW'(1);
    assign wr_addr = restart ? '0 : x_q;
    assign c_word  = mid_mem[x_q];
    assign r_word  = mid_mem[r_addr];
    assign u_word  = up_mem[x_q];

    assign l_ok = (x_q != '0) && !l_q[PW];
    assign r_ok = !x_last && !r_word[PW];
    assign u_ok = (y_q != '0) && !u_word[PW];
    assign d_ok = (state_q == ST_RUN) && !in_word[PW];

    assign sum_h = {1'b0, l_q[PW-1:0]} + {1'b0, r_word[PW-1:0]};
    assign sum_v = {1'b0, u_word[PW-1:0]} + {1'b0, in_word[PW-1:0]};
    assign avg_h = sum_h[PW:1];
    assign avg_v = sum_v[PW:1];

    always_comb begin
        repl  = last_pix_q;
        no_nb = 1'b0;
        if (!mode_q) begin
            if (l_ok && r_ok)      repl = avg_h;
            else if (u_ok && d_ok) repl = avg_v;
            else if (l_ok)         repl = l_q[PW-1:0];
            else if (r_ok)         repl = r_word[PW-1:0];
            else if (u_ok)         repl = u_word[PW-1:0];
            else if (d_ok)         repl = in_word[PW-1:0];
            else                   no_nb = 1'b1;
        end else begin
            if (u_ok && d_ok)      repl = avg_v;
            else if (l_ok && r_ok) repl = avg_h;
            else if (u_ok)         repl = u_word[PW-1:0];
            else if (d_ok)         repl = in_word[PW-1:0];
            else if (l_ok)         repl = l_q[PW-1:0];
            else if (r_ok)         repl = r_word[PW-1:0];
            else                   no_nb = 1'b1;
        end
    end

    assign out_pix   = (c_word[PW] && !bypass_q) ? repl : c_word[PW-1:0];
    assign unfix_hit = c_word[PW] && !bypass_q && no_nb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (fill_adv && x_last) state_d = ST_RUN;
            ST_RUN: begin
                if (restart)                          state_d = ST_FILL;
                else if (run_beat && x_last && y_last_in) state_d = ST_FLUSH;
            end
            ST_FLUSH: if (flush_done) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) state_q <= ST_FILL;
        else               state_q <= state_d;
    end

    always_ff @(posedge axis_aclk) begin
        if (restart || fill_adv || run_beat) mid_mem[wr_addr] <= in_word;
        if (run_beat)                         up_mem[x_q]      <= c_word;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            x_q            <= '0;
            y_q            <= '0;
            live_q         <= 1'b0;
            bypass_q       <= 1'b0;
            mode_q         <= 1'b0;
            flush_issued_q <= 1'b0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_user_q       <= 1'b0;
            m_data_q       <= '0;
            last_pix_q     <= '0;
            l_q            <= '0;
            frm_bad_q      <= '0;
            frm_unfix_q    <= '0;
            bad_cnt        <= '0;
            unfix_cnt      <= '0;
            sync_err       <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (in_hs && (sof != at_origin)) sync_err <= 1'b1;
            if (m_valid_q && m_axis.tready)  m_valid_q <= 1'b0;

            if (restart) begin
                x_q            <= XW'(1);
                y_q            <= '0;
                bypass_q       <= bypass;
                mode_q         <= mode;
                frm_bad_q      <= '0;
                frm_unfix_q    <= '0;
                flush_issued_q <= 1'b0;
            end else if (fill_adv) begin
                x_q <= x_last ? '0 : x_q + XW'(1);
            end else if (run_beat) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last_in ? YW'(IMG_RES_Y-1) : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end else if (flush_beat) begin
                x_q <= x_last ? '0 : x_q + XW'(1);
                if (x_last) flush_issued_q <= 1'b1;
            end else if (flush_done) begin
                flush_issued_q <= 1'b0;
                y_q            <= '0;
                bad_cnt        <= frm_bad_q;
                unfix_cnt      <= frm_unfix_q;
            end

            if (emit) begin
                m_valid_q   <= 1'b1;
                m_data_q    <= TDATA_WIDTH'(out_pix);
                m_last_q    <= x_last;
                m_user_q    <= (x_q == '0) && (y_q == '0);
                last_pix_q  <= out_pix;
                l_q         <= c_word;
                frm_bad_q   <= frm_bad_q + CNT_WIDTH'(c_word[PW]);
                frm_unfix_q <= frm_unfix_q + CNT_WIDTH'(unfix_hit);
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tuser  = m_user_q;
    assign dbg_state     = state_q;
endmodule
